// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
// Build option: define MDU_MADD_EN to enable madd (MDop=100).
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDop,
    input  logic        HIwrite,
    input  logic        LOwrite,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b100;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        C_SET,
        C_KEEP,
        C_ADD
    } commit_t;

    state_t      state;
    commit_t     kind;
    logic [3:0]  cnt;
    logic [31:0] t_hi;
    logic [31:0] t_lo;

    logic        op_legal;
    logic        is_div;
    logic        is_signed;
    logic        is_madd;

    always_comb begin
        op_legal  = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_madd   = 1'b0;
        unique case (MDop)
            OP_MULTU: begin
                op_legal = 1'b1;
            end
            OP_MULT: begin
                op_legal  = 1'b1;
                is_signed = 1'b1;
            end
            OP_DIVU: begin
                op_legal = 1'b1;
                is_div   = 1'b1;
            end
            OP_DIV: begin
                op_legal  = 1'b1;
                is_div    = 1'b1;
                is_signed = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                op_legal  = 1'b1;
                is_signed = 1'b1;
                is_madd   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Sign-extending to 64 bits lets one multiplier serve both signednesses.
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    assign ext_a = {{32{is_signed & A[31]}}, A};
    assign ext_b = {{32{is_signed & B[31]}}, B};
    assign prod  = ext_a * ext_b;

    // Signed divide runs on magnitudes, then fixes signs; this also
    // yields 0x80000000 / -1 = 0x80000000 remainder 0 without overflow.
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign a_neg  = is_signed & A[31];
    assign b_neg  = is_signed & B[31];
    assign b_zero = (B == 32'd0);
    assign a_mag  = a_neg ? (32'd0 - A) : A;
    assign b_mag  = b_neg ? (32'd0 - B) : B;
    assign b_div  = b_zero ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_div;
    assign r_mag  = a_mag % b_div;
    assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    logic accept;
    logic mt_ok;

    assign accept = (state == IDLE) && start && op_legal;
    assign mt_ok  = (state == IDLE) && !start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            kind  <= C_KEEP;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            t_hi  <= 32'd0;
            t_lo  <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        if (is_div) begin
                            cnt  <= DIV_N;
                            t_hi <= rem;
                            t_lo <= quo;
                            kind <= b_zero ? C_KEEP : C_SET;
                        end else begin
                            cnt  <= MULT_N;
                            t_hi <= prod[63:32];
                            t_lo <= prod[31:0];
                            kind <= is_madd ? C_ADD : C_SET;
                        end
                    end else if (mt_ok) begin
                        if (HIwrite) begin
                            HI <= A;
                        end
                        if (LOwrite) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                        unique case (kind)
                            C_SET: begin
                                HI <= t_hi;
                                LO <= t_lo;
                            end
`ifdef MDU_MADD_EN
                            // Accumulate onto HI/LO as they stand at commit.
                            C_ADD: begin
                                {HI, LO} <= {HI, LO} + {t_hi, t_lo};
                            end
`endif
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
// Table of op vectors plus hand sequences for reset, mthi/mtlo and busy corners.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDop;
    logic        HIwrite;
    logic        LOwrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int bad;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDop   (MDop),
        .HIwrite(HIwrite),
        .LOwrite(LOwrite),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue op at current negedge; return after busy drops (or timeout).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] phi,
                         input logic [31:0] plo, output int n);
        start = 1'b1;
        MDop  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 2) begin
                check("hi_hold", HI, phi);
                check("lo_hold", LO, plo);
            end
            @(negedge clk);
        end
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] v);
        HIwrite = hw;
        LOwrite = lw;
        A       = v;
        @(negedge clk);
        HIwrite = 1'b0;
        LOwrite = 1'b0;
    endtask

    logic [31:0] phi;
    logic [31:0] plo;
    int          n;

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        start   = 1'b0;
        MDop    = 3'b000;
        HIwrite = 1'b0;
        LOwrite = 1'b0;
        A       = 32'd0;
        B       = 32'd0;

        vecs[0]  = '{"multu_ff_2", 3'b000, 32'hFFFFFFFF, 32'd2, 5,
                     32'h00000001, 32'hFFFFFFFE};
        vecs[1]  = '{"mult_m2_3", 3'b001, 32'hFFFFFFFE, 32'd3, 5,
                     32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[2]  = '{"multu_2p32", 3'b000, 32'h00010000, 32'h00010000, 5,
                     32'h00000001, 32'h00000000};
        vecs[3]  = '{"mult_min_min", 3'b001, 32'h80000000, 32'h80000000, 5,
                     32'h40000000, 32'h00000000};
        vecs[4]  = '{"divu_100_7", 3'b010, 32'd100, 32'd7, 10,
                     32'd2, 32'd14};
        vecs[5]  = '{"div_m7_2", 3'b011, 32'hFFFFFFF9, 32'd2, 10,
                     32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6]  = '{"div_7_m2", 3'b011, 32'd7, 32'hFFFFFFFE, 10,
                     32'd1, 32'hFFFFFFFD};
        vecs[7]  = '{"div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 10,
                     32'd0, 32'h80000000};
        vecs[8]  = '{"divu_by0", 3'b010, 32'd55, 32'd0, 10,
                     32'd0, 32'h80000000};
        vecs[9]  = '{"div_by0", 3'b011, 32'hFFFFFF00, 32'd0, 10,
                     32'd0, 32'h80000000};
        vecs[10] = '{"divu_max_1", 3'b010, 32'hFFFFFFFF, 32'd1, 10,
                     32'd0, 32'hFFFFFFFF};

        #1 reset = 1'b0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        mt(1'b1, 1'b0, 32'h00001234);
        check("mthi", HI, 32'h00001234);
        check("mthi_lo", LO, 32'd0);
        mt(1'b0, 1'b1, 32'h00000055);
        check("mtlo", LO, 32'h00000055);
        mt(1'b1, 1'b1, 32'h000000AB);
        check("mthilo_hi", HI, 32'h000000AB);
        check("mthilo_lo", LO, 32'h000000AB);

        // Back-to-back: each op starts the cycle right after busy falls.
        phi = 32'h000000AB;
        plo = 32'h000000AB;
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, phi, plo, n);
            check({vecs[i].name, "_cyc"}, 32'(n), 32'(vecs[i].cycles));
            check({vecs[i].name, "_hi"}, HI, vecs[i].hi);
            check({vecs[i].name, "_lo"}, LO, vecs[i].lo);
            phi = vecs[i].hi;
            plo = vecs[i].lo;
        end

        mt(1'b1, 1'b0, 32'h00001234);
        mt(1'b0, 1'b1, 32'h00000077);
        start = 1'b1;
        MDop  = 3'b010;
        A     = 32'd5;
        B     = 32'd0;
        @(negedge clk);
        start   = 1'b1;
        MDop    = 3'b001;
        HIwrite = 1'b1;
        A       = 32'h0000DEAD;
        B       = 32'd3;
        @(negedge clk);
        start   = 1'b0;
        HIwrite = 1'b0;
        n = 1;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("ign_cyc", 32'(n), 32'd10);
        check("ign_hi", HI, 32'h00001234);
        check("ign_lo", LO, 32'h00000077);
        repeat (3) @(negedge clk);
        check("ign_nobusy", {31'd0, busy}, 32'd0);
        check("ign_hi2", HI, 32'h00001234);

        start = 1'b1;
        MDop  = 3'b101;
        @(negedge clk);
        MDop  = 3'b111;
        @(negedge clk);
        start = 1'b0;
        check("illegal_busy", {31'd0, busy}, 32'd0);
        check("illegal_lo", LO, 32'h00000077);

`ifdef MDU_MADD_EN
        mt(1'b1, 1'b0, 32'd0);
        mt(1'b0, 1'b1, 32'd5);
        do_op(3'b100, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd5, n);
        check("madd_cyc", 32'(n), 32'd5);
        check("madd_hi", HI, 32'd0);
        check("madd_lo", LO, 32'd2);
`else
        start = 1'b1;
        MDop  = 3'b100;
        A     = 32'hFFFFFFFF;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("madd_off_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("madd_off_busy2", {31'd0, busy}, 32'd0);
        check("madd_off_lo", LO, 32'h00000077);
`endif

        start = 1'b1;
        MDop  = 3'b011;
        A     = 32'd100;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_hi", HI, 32'd0);
        check("mid_rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
